// File: rtl/rgb_hsv_classifier_pipe.sv
// Three-stage RGB -> S/V converter with red/green pixel classifier and per-frame verdict.
// Optional hue output enabled by defining HSV_HUE_OUT_EN.
module rgb_hsv_classifier_pipe #(
  parameter int R_W       = 5,
  parameter int G_W       = 6,
  parameter int B_W       = 5,
  parameter int OUT_W     = 8,
  parameter int CNT_W     = 19,
  parameter int GRN_R_MAX = 120,
  parameter int GRN_G_MIN = 180,
  parameter int GRN_B_MAX = 120,
  parameter int RED_R_MIN = 190,
  parameter int RED_G_MAX = 100,
  parameter int RED_B_MAX = 100,
  parameter int MIN_PIX   = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic             in_eof,
  input  logic [R_W-1:0]   r_data,
  input  logic [G_W-1:0]   g_data,
  input  logic [B_W-1:0]   b_data,
  output logic             out_valid,
  output logic [1:0]       r_g_decision,
  output logic [OUT_W-1:0] s_data,
  output logic [OUT_W-1:0] v_data,
  output logic             frame_valid,
  output logic [1:0]       frame_decision,
  output logic [CNT_W-1:0] red_cnt,
  output logic [CNT_W-1:0] green_cnt
`ifdef HSV_HUE_OUT_EN
  ,
  output logic [OUT_W-1:0] h_data
`endif
);

  typedef enum logic [1:0] {CLS_RED = 2'd0, CLS_GREEN = 2'd1, CLS_NONE = 2'd2} cls_t;
  typedef enum logic {IDLE, ACCUM} state_t;

  localparam int R_REP = OUT_W / R_W + 1;
  localparam int G_REP = OUT_W / G_W + 1;
  localparam int B_REP = OUT_W / B_W + 1;
  localparam int MW    = 2 * OUT_W;
  localparam int CMP_W = (CNT_W > 32) ? CNT_W : 32;

  localparam logic [OUT_W-1:0] GRN_R_LIM = OUT_W'(GRN_R_MAX);
  localparam logic [OUT_W-1:0] GRN_G_LIM = OUT_W'(GRN_G_MIN);
  localparam logic [OUT_W-1:0] GRN_B_LIM = OUT_W'(GRN_B_MAX);
  localparam logic [OUT_W-1:0] RED_R_LIM = OUT_W'(RED_R_MIN);
  localparam logic [OUT_W-1:0] RED_G_LIM = OUT_W'(RED_G_MAX);
  localparam logic [OUT_W-1:0] RED_B_LIM = OUT_W'(RED_B_MAX);
  localparam logic [CMP_W-1:0] MIN_LIM   = CMP_W'(MIN_PIX);

  // MSB replication: repeat the channel and keep the top OUT_W bits
  logic [R_REP*R_W-1:0] r_rep;
  logic [G_REP*G_W-1:0] g_rep;
  logic [B_REP*B_W-1:0] b_rep;
  assign r_rep = {R_REP{r_data}};
  assign g_rep = {G_REP{g_data}};
  assign b_rep = {B_REP{b_data}};

  // Stage 1
  logic             v1, sof1, eof1;
  logic [OUT_W-1:0] r1, g1, b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1 <= 1'b0; sof1 <= 1'b0; eof1 <= 1'b0;
      r1 <= '0;   g1 <= '0;     b1 <= '0;
    end else begin
      v1   <= in_valid;
      sof1 <= in_valid & in_sof;
      eof1 <= in_valid & in_eof;
      if (in_valid) begin
        r1 <= r_rep[R_REP*R_W-1 -: OUT_W];
        g1 <= g_rep[G_REP*G_W-1 -: OUT_W];
        b1 <= b_rep[B_REP*B_W-1 -: OUT_W];
      end
    end
  end

  // Stage 2
  logic [OUT_W-1:0] mx1, mn1;
  cls_t             cls1;

  always_comb begin
    mx1 = r1;
    if (g1 > mx1) mx1 = g1;
    if (b1 > mx1) mx1 = b1;
    mn1 = r1;
    if (g1 < mn1) mn1 = g1;
    if (b1 < mn1) mn1 = b1;
    if (r1 <= GRN_R_LIM && g1 >= GRN_G_LIM && b1 <= GRN_B_LIM)
      cls1 = CLS_GREEN;
    else if (r1 >= RED_R_LIM && g1 <= RED_G_LIM && b1 <= RED_B_LIM)
      cls1 = CLS_RED;
    else
      cls1 = CLS_NONE;
  end

  logic             v2, sof2, eof2;
  logic [OUT_W-1:0] mx2, mn2;
  cls_t             cls2;
`ifdef HSV_HUE_OUT_EN
  logic [OUT_W-1:0] r2, g2, b2;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v2 <= 1'b0; sof2 <= 1'b0; eof2 <= 1'b0;
      mx2 <= '0;  mn2 <= '0;    cls2 <= CLS_NONE;
`ifdef HSV_HUE_OUT_EN
      r2 <= '0; g2 <= '0; b2 <= '0;
`endif
    end else begin
      v2   <= v1;
      sof2 <= v1 & sof1;
      eof2 <= v1 & eof1;
      if (v1) begin
        mx2  <= mx1;
        mn2  <= mn1;
        cls2 <= cls1;
`ifdef HSV_HUE_OUT_EN
        r2 <= r1; g2 <= g1; b2 <= b1;
`endif
      end
    end
  end

  // Stage 3: saturation divide at full 2*OUT_W precision
  logic [OUT_W-1:0] d2, s2;
  logic [MW-1:0]    s_num, s_den, s_quo;

  always_comb begin
    d2    = mx2 - mn2;
    s_num = MW'(d2) * MW'({OUT_W{1'b1}});
    s_den = (mx2 == '0) ? MW'(1) : MW'(mx2);
    s_quo = s_num / s_den;
    s2    = (mx2 == '0) ? '0 : s_quo[OUT_W-1:0];
  end

`ifdef HSV_HUE_OUT_EN
  localparam int HW = MW + 2;
  localparam logic signed [HW-1:0] K43 = HW'(43);
  logic signed [HW-1:0] h_dif, h_num, h_den, h_quo;
  logic [OUT_W-1:0]     h_base, h2;

  always_comb begin
    if (mx2 == r2) begin
      h_dif  = $signed(HW'(g2)) - $signed(HW'(b2));
      h_base = OUT_W'(0);
    end else if (mx2 == g2) begin
      h_dif  = $signed(HW'(b2)) - $signed(HW'(r2));
      h_base = OUT_W'(85);
    end else begin
      h_dif  = $signed(HW'(r2)) - $signed(HW'(g2));
      h_base = OUT_W'(171);
    end
    h_num = h_dif * K43;
    h_den = (d2 == '0) ? HW'(1) : $signed(HW'(d2));
    h_quo = h_num / h_den;
    h2    = (d2 == '0) ? '0 : h_base + h_quo[OUT_W-1:0];
  end
`endif

  logic sof3, eof3;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0; sof3 <= 1'b0; eof3 <= 1'b0;
      r_g_decision <= CLS_NONE;
      s_data <= '0; v_data <= '0;
`ifdef HSV_HUE_OUT_EN
      h_data <= '0;
`endif
    end else begin
      out_valid <= v2;
      sof3      <= v2 & sof2;
      eof3      <= v2 & eof2;
      if (v2) begin
        r_g_decision <= cls2;
        s_data       <= s2;
        v_data       <= mx2;
`ifdef HSV_HUE_OUT_EN
        h_data       <= h2;
`endif
      end
    end
  end

  // Frame accumulation on the output pixel stream
  state_t           state, state_nx;
  logic [CNT_W-1:0] red_acc, grn_acc, red_nx, grn_nx;
  logic             is_red, is_grn, count_en, close;
  logic [CMP_W-1:0] red_w, grn_w;
  cls_t             verdict;

  always_comb begin
    state_nx = state;
    if (out_valid) begin
      if (sof3)
        state_nx = eof3 ? IDLE : ACCUM;
      else if (state == ACCUM && eof3)
        state_nx = IDLE;
    end
  end

  always_comb begin
    is_red   = (r_g_decision == CLS_RED);
    is_grn   = (r_g_decision == CLS_GREEN);
    count_en = out_valid & (sof3 | (state == ACCUM));
    close    = count_en & eof3;
    // sof loads the pixel's own class instead of clearing then adding
    if (sof3) begin
      red_nx = CNT_W'(is_red);
      grn_nx = CNT_W'(is_grn);
    end else begin
      red_nx = (red_acc == '1) ? red_acc : red_acc + CNT_W'(is_red);
      grn_nx = (grn_acc == '1) ? grn_acc : grn_acc + CNT_W'(is_grn);
    end
    red_w = CMP_W'(red_nx);
    grn_w = CMP_W'(grn_nx);
    if (red_w >= MIN_LIM && red_w > grn_w)
      verdict = CLS_RED;
    else if (grn_w >= MIN_LIM && grn_w > red_w)
      verdict = CLS_GREEN;
    else
      verdict = CLS_NONE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      red_acc <= '0; grn_acc <= '0;
      frame_valid <= 1'b0;
      frame_decision <= CLS_NONE;
      red_cnt <= '0; green_cnt <= '0;
    end else begin
      frame_valid <= close;
      if (count_en) begin
        red_acc <= red_nx;
        grn_acc <= grn_nx;
      end
      if (close) begin
        red_cnt        <= red_nx;
        green_cnt      <= grn_nx;
        frame_decision <= verdict;
      end
    end
  end

endmodule

// File: tb/tb_rgb_hsv_classifier_pipe.sv
// Directed self-checking bench for rgb_hsv_classifier_pipe (default and CNT_W=4 instances).
module tb_rgb_hsv_classifier_pipe;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_valid, in_sof, in_eof;
  logic [4:0] r_data;
  logic [5:0] g_data;
  logic [4:0] b_data;

  logic        out_valid, frame_valid;
  logic [1:0]  r_g_decision, frame_decision;
  logic [7:0]  s_data, v_data;
  logic [18:0] red_cnt, green_cnt;

  logic        out_valid4, frame_valid4;
  logic [1:0]  r_g_decision4, frame_decision4;
  logic [7:0]  s_data4, v_data4;
  logic [3:0]  red_cnt4, green_cnt4;
`ifdef HSV_HUE_OUT_EN
  logic [7:0]  h_data, h_data4;
`endif

  int errors = 0;
  int checks = 0;
  int fv = 0;
  int fv4 = 0;
  int f0, f40;
  logic [7:0] pat;

  rgb_hsv_classifier_pipe dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_sof(in_sof), .in_eof(in_eof),
    .r_data(r_data), .g_data(g_data), .b_data(b_data),
    .out_valid(out_valid), .r_g_decision(r_g_decision), .s_data(s_data), .v_data(v_data),
    .frame_valid(frame_valid), .frame_decision(frame_decision),
    .red_cnt(red_cnt), .green_cnt(green_cnt)
`ifdef HSV_HUE_OUT_EN
    , .h_data(h_data)
`endif
  );

  rgb_hsv_classifier_pipe #(.CNT_W(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_sof(in_sof), .in_eof(in_eof),
    .r_data(r_data), .g_data(g_data), .b_data(b_data),
    .out_valid(out_valid4), .r_g_decision(r_g_decision4), .s_data(s_data4), .v_data(v_data4),
    .frame_valid(frame_valid4), .frame_decision(frame_decision4),
    .red_cnt(red_cnt4), .green_cnt(green_cnt4)
`ifdef HSV_HUE_OUT_EN
    , .h_data(h_data4)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_valid === 1'b1)  fv++;
    if (frame_valid4 === 1'b1) fv4++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic s, input logic e,
                       input logic [4:0] r, input logic [5:0] g, input logic [4:0] b);
    @(negedge clk);
    in_valid = v; in_sof = s; in_eof = e;
    r_data = r; g_data = g; b_data = b;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 5'd0, 6'd0, 5'd0);
  endtask

  // kind: 0 red, 1 green, 2 none
  task automatic pix(input int kind, input logic s, input logic e);
    case (kind)
      0:       drive(1'b1, s, e, 5'd31, 6'd0, 5'd0);
      1:       drive(1'b1, s, e, 5'd0, 6'd63, 5'd0);
      default: drive(1'b1, s, e, 5'd0, 6'd0, 5'd0);
    endcase
  endtask

  task automatic send_frame(input int nr, input int ng, input int nn);
    int total;
    total = nr + ng + nn;
    for (int i = 0; i < total; i++)
      pix((i < nr) ? 0 : ((i < nr + ng) ? 1 : 2), i == 0, i == total - 1);
    idle(6);
  endtask

  task automatic px_test(input string tag, input logic [4:0] r, input logic [5:0] g,
                         input logic [4:0] b, input int dec, input int s, input int v, input int h);
    drive(1'b1, 1'b0, 1'b0, r, g, b);
    drive(1'b0, 1'b0, 1'b0, 5'd0, 6'd0, 5'd0);
    check({tag, "_lat1"}, out_valid, 0);
    drive(1'b0, 1'b0, 1'b0, 5'd0, 6'd0, 5'd0);
    check({tag, "_lat2"}, out_valid, 0);
    drive(1'b0, 1'b0, 1'b0, 5'd0, 6'd0, 5'd0);
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_dec"}, r_g_decision, dec);
    check({tag, "_s"}, s_data, s);
    check({tag, "_v"}, v_data, v);
`ifdef HSV_HUE_OUT_EN
    check({tag, "_h"}, h_data, h);
`else
    if (h < 0) checks = checks + 0;
`endif
    drive(1'b0, 1'b0, 1'b0, 5'd0, 6'd0, 5'd0);
    check({tag, "_bubble"}, out_valid, 0);
    check({tag, "_hold_v"}, v_data, v);
  endtask

  task automatic frame_check(input string tag, input int base, input int nfv,
                             input int red, input int grn, input int dec);
    check({tag, "_pulses"}, fv - base, nfv);
    check({tag, "_red"}, red_cnt, red);
    check({tag, "_green"}, green_cnt, grn);
    check({tag, "_dec"}, frame_decision, dec);
  endtask

  initial begin
    reset_n = 1'b0;
    in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
    r_data = '0; g_data = '0; b_data = '0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_dec", r_g_decision, 2);
    check("rst_s", s_data, 0);
    check("rst_v", v_data, 0);
    check("rst_frame_valid", frame_valid, 0);
    check("rst_frame_dec", frame_decision, 2);
    check("rst_red_cnt", red_cnt, 0);
    check("rst_green_cnt", green_cnt, 0);
    reset_n = 1'b1;
    idle(2);

    px_test("red",   5'd31, 6'd0,  5'd0,  0, 255, 255, 0);
    px_test("green", 5'd0,  6'd63, 5'd0,  1, 255, 255, 85);
    px_test("black", 5'd0,  6'd0,  5'd0,  2, 0,   0,   0);
    px_test("grey",  5'd16, 6'd32, 5'd16, 2, 3,   132, 213);

    pat = 8'b0100_1101;
    for (int i = 0; i < 11; i++) begin
      drive((i < 8) ? pat[i] : 1'b0, 1'b0, 1'b0, 5'd16, 6'd32, 5'd16);
      if (i < 3) check("alt_lead", out_valid, 0);
      else       check("alt_pattern", out_valid, pat[i-3]);
    end
    idle(3);

    f0 = fv; send_frame(100, 20, 30);
    frame_check("frm_red_win", f0, 1, 100, 20, 0);
    f0 = fv; send_frame(64, 64, 0);
    frame_check("frm_tie", f0, 1, 64, 64, 2);
    f0 = fv; send_frame(5, 70, 0);
    frame_check("frm_green_win", f0, 1, 5, 70, 1);
    f0 = fv; send_frame(64, 0, 0);
    frame_check("frm_min_edge", f0, 1, 64, 0, 0);
    f0 = fv; send_frame(63, 0, 1);
    frame_check("frm_below_min", f0, 1, 63, 0, 2);

    f0 = fv; f40 = fv4; send_frame(20, 0, 0);
    frame_check("frm_20red", f0, 1, 20, 0, 2);
    check("cnt4_pulses", fv4 - f40, 1);
    check("cnt4_red_sat", red_cnt4, 15);
    check("cnt4_dec", frame_decision4, 2);

    f0 = fv; f40 = fv4;
    pix(0, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) pix(0, 1'b0, 1'b0);
    send_frame(0, 70, 0);
    frame_check("abort", f0, 1, 0, 70, 1);
    check("abort_cnt4_pulses", fv4 - f40, 1);
    check("abort_cnt4_green_sat", green_cnt4, 15);

    f0 = fv;
    pix(0, 1'b1, 1'b1);
    idle(6);
    frame_check("single_pix", f0, 1, 1, 0, 2);

    f0 = fv;
    for (int i = 0; i < 3; i++) pix(0, 1'b0, 1'b0);
    pix(0, 1'b0, 1'b1);
    idle(6);
    frame_check("stray_idle", f0, 0, 1, 0, 2);

    send_frame(70, 0, 0);
    check("pre_reset_dec", frame_decision, 0);
    pix(1, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) pix(1, 1'b0, 1'b0);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_dec", r_g_decision, 2);
    check("mid_rst_s", s_data, 0);
    check("mid_rst_v", v_data, 0);
    check("mid_rst_frame_valid", frame_valid, 0);
    check("mid_rst_frame_dec", frame_decision, 2);
    check("mid_rst_red_cnt", red_cnt, 0);
    check("mid_rst_green_cnt", green_cnt, 0);
    #5 reset_n = 1'b1;
    f0 = fv;
    for (int i = 0; i < 19; i++) pix(1, 1'b0, 1'b0);
    pix(1, 1'b0, 1'b1);
    idle(6);
    frame_check("post_rst_tail", f0, 0, 0, 0, 2);
    f0 = fv; send_frame(0, 66, 0);
    frame_check("post_rst_frame", f0, 1, 0, 66, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
